ps2_keyscan: RTL
================

Name: ps2_keyscan

Overview:
PS/2 keyboard receiver that sits directly upstream of the top-level keyboard inputs and drives kstb/make/code. It synchronises and deglitches the raw PS/2 clock and data lines and deserialises 11-bit device-to-host frames. It resolves the scan-code set 2 prefixes (E0 extended, F0 break, E1 pause) and emits one strobed key event per complete key code. Runs on the 56 MHz system clock; it has no clock enable.

Parameters:
FILTER, 8, consecutive identical synchronised samples required before the filtered ps2ck/ps2d level changes
TIMEOUT, 56000, clocks without a ps2ck falling edge mid-frame before the partial frame is discarded (about 1 ms at 56 MHz)

Ports:
clock  input  1  system clock, 56 MHz, all logic on posedge
reset  input  1  synchronous, active-high reset
ps2ck  input  1  raw PS/2 clock from pad, asynchronous
ps2d   input  1  raw PS/2 data from pad, asynchronous
kstb   output 1  one-clock strobe: a new key event is valid on make/ext/code
make   output 1  1 = key press, 0 = key release (an F0 prefix was seen)
ext    output 1  1 = an E0 prefix preceded this code
code   output 8  scan code (set 2), without prefixes
perr   output 1  one-clock pulse when a frame is rejected (bad parity or stop bit)

Behaviour:
- Reset is synchronous and active-high. While reset is high: kstb=0, perr=0, make=0, ext=0, code=8'h00. The bit counter, shift register, timeout counter and prefix flags are cleared, and the filtered lines are set to 1. Asserting reset mid-frame discards the partial frame with no perr pulse.
- Input path: a 2-flop synchroniser on each line, then a per-line counter. The filtered level follows the synchronised level only after FILTER consecutive equal samples. A fall event is the filtered ps2ck going 1->0; it lasts one clock.
- Frame FSM has two states, IDLE and SHIFT.
  - IDLE: on a fall event with filtered ps2d=0 (start bit), go to SHIFT with bit count 0. On a fall event with ps2d=1, ignore it and stay in IDLE.
  - SHIFT: each fall event samples ps2d. Samples 1-8 are data bits, LSB first. Sample 9 is parity (odd over data and parity). Sample 10 is the stop bit, which must be 1. After sample 10, return to IDLE.
  - The timeout counter is cleared on every fall event and counts while in SHIFT. When it reaches TIMEOUT, return to IDLE silently with no perr and no flag change.
- Frame check, in the clock of sample 10:
  - If parity is bad or stop=0: perr=1 on the next clock only, the E0/F0 flags are cleared, and no kstb.
  - Otherwise the byte goes to the prefix stage in the same clock.
- Prefix stage, applied to each valid byte:
  - E0: set ext_f, no output.
  - F0: set brk_f, no output.
  - E1: load the pause-skip counter with 7. While the counter is nonzero, each valid byte decrements it and is discarded. No event is produced for Pause.
  - 00, AA, EE, FA, FC, FD, FE, FF (control/response bytes) arriving with no prefix flag set: discarded.
  - Any other byte: on the next clock kstb=1 for exactly one clock, with code=byte, make=!brk_f and ext=ext_f. Both flags are cleared in the same clock.
- Latency: kstb asserts exactly 1 clock after the clock in which the stop-bit fall event is seen.
- code, make and ext change only together with kstb and hold their values until the next kstb.
- perr and kstb are never high in the same clock.
- Widths: the filter counters are sized to hold FILTER and the timeout counter to hold TIMEOUT. The skip counter is 3 bits. Counters saturate or clear and never wrap.

Test Plan:
- After reset, send the frame for 1C (parity 0, stop 1) -> one kstb pulse with code=8'h1C, make=1, ext=0, one clock after the stop edge; perr stays 0.
- Send F0 1C -> a single kstb with code=8'h1C, make=0, ext=0. Then send E0 F0 75 -> a single kstb with code=8'h75, make=0, ext=1; flags are clear afterwards (a following 1C gives make=1, ext=0).
- Send E1 14 77 E1 F0 14 F0 77, then 29 -> no kstb for the first 8 bytes, then exactly one kstb with code=8'h29, make=1.
- Send E0, then 1C with parity flipped -> perr pulses once and there is no kstb. Then send 1C -> kstb with ext=0 (the E0 flag was cleared).
- Send start bit plus 4 data bits, hold ps2ck high for more than TIMEOUT clocks, then send a full 2B -> only one kstb, with code=8'h2B, and no perr.
- Inject glitches of FILTER-1 clocks on ps2ck during a 1C frame, and separately assert reset in the middle of a frame -> glitches cause no extra bits and the 1C is decoded correctly; after reset all outputs are 0 and the next full frame decodes normally.

Source files
------------

// File: rtl/ps2_keyscan.sv
`timescale 1ns/1ps
// ps2_keyscan_filt: one PS/2 line conditioner.
//   clock, reset : system clock / synchronous active-high reset
//   raw          : asynchronous pad level
//   filt         : synchronised level, changes only after FILTER
//                  consecutive samples that differ from the current value
module ps2_keyscan_filt #(
  parameter int FILTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int CW = $clog2(FILTER + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      // any sample matching the current level restarts the run
      if (sync[1] == filt)               cnt <= '0;
      else if (cnt == CW'(FILTER - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else                           cnt <= cnt + CW'(1);
    end
  end
endmodule

// ps2_keyscan: PS/2 keyboard receiver, scan-code set 2.
//   clock, reset : 56 MHz system clock / synchronous active-high reset
//   ps2ck, ps2d  : raw PS/2 clock and data from the pads
//   kstb         : one-clock strobe, new event on make/ext/code
//   make         : 1 press, 0 release (F0 seen)
//   ext          : E0 prefix preceded this code
//   code         : scan code without prefixes
//   perr         : one-clock pulse on a rejected frame (parity / stop)
module ps2_keyscan #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 56000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2ck,
  input  logic       ps2d,
  output logic       kstb,
  output logic       make,
  output logic       ext,
  output logic [7:0] code,
  output logic       perr
);
  localparam int TW = $clog2(TIMEOUT + 1);

  // line 0 = clock, line 1 = data
  logic [1:0] raw_v, filt_v;
  assign raw_v = {ps2d, ps2ck};

  for (genvar i = 0; i < 2; i++) begin : g_line
    ps2_keyscan_filt #(.FILTER(FILTER)) u_filt (
      .clock (clock),
      .reset (reset),
      .raw   (raw_v[i]),
      .filt  (filt_v[i])
    );
  end

  logic ck_f, d_f, ck_q, fall;
  assign ck_f = filt_v[0];
  assign d_f  = filt_v[1];
  assign fall = ck_q & ~ck_f;

  always_ff @(posedge clock) begin
    if (reset) ck_q <= 1'b1;
    else       ck_q <= ck_f;
  end

  // ---------------- frame FSM ----------------
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t        state, state_nx;
  logic [3:0]    bcnt, bcnt_nx;
  logic [8:0]    sh, sh_nx;      // {parity, data[7:0]} once 9 samples are in
  logic [TW-1:0] tocnt, tocnt_nx;
  logic          frm_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      bcnt  <= '0;
      sh    <= '0;
      tocnt <= '0;
    end else begin
      state <= state_nx;
      bcnt  <= bcnt_nx;
      sh    <= sh_nx;
      tocnt <= tocnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    bcnt_nx  = bcnt;
    sh_nx    = sh;
    tocnt_nx = tocnt;
    frm_done = 1'b0;
    case (state)
      IDLE: begin
        tocnt_nx = '0;
        if (fall && !d_f) begin
          state_nx = SHIFT;
          bcnt_nx  = '0;
        end
      end
      SHIFT: begin
        if (fall) begin
          tocnt_nx = '0;
          if (bcnt == 4'd9) begin
            // stop bit: checked combinationally, not stored
            frm_done = 1'b1;
            state_nx = IDLE;
          end else begin
            sh_nx   = {d_f, sh[8:1]};
            bcnt_nx = bcnt + 4'd1;
          end
        end else if (tocnt == TW'(TIMEOUT)) begin
          state_nx = IDLE;
          tocnt_nx = '0;
        end else begin
          tocnt_nx = tocnt + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic       frm_ok, frm_bad, is_ctl;
  logic [7:0] byte_v;
  assign byte_v  = sh[7:0];
  assign frm_ok  = frm_done & (^sh) & d_f;   // odd parity and stop = 1
  assign frm_bad = frm_done & ~frm_ok;

  always_comb begin
    is_ctl = 1'b0;
    case (byte_v)
      8'h00, 8'hAA, 8'hEE, 8'hFA,
      8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ctl = 1'b1;
      default:                    is_ctl = 1'b0;
    endcase
  end

  // ---------------- prefix stage ----------------
  logic       ext_f, brk_f;
  logic [2:0] skip;

  always_ff @(posedge clock) begin
    if (reset) begin
      kstb  <= 1'b0;
      perr  <= 1'b0;
      make  <= 1'b0;
      ext   <= 1'b0;
      code  <= 8'h00;
      ext_f <= 1'b0;
      brk_f <= 1'b0;
      skip  <= '0;
    end else begin
      kstb <= 1'b0;
      perr <= 1'b0;
      if (frm_bad) begin
        perr  <= 1'b1;
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (frm_ok) begin
        // Pause is E1 plus 7 bytes; swallow them without touching flags
        if (skip != 3'd0)                     skip  <= skip - 3'd1;
        else if (byte_v == 8'hE1)             skip  <= 3'd7;
        else if (byte_v == 8'hE0)             ext_f <= 1'b1;
        else if (byte_v == 8'hF0)             brk_f <= 1'b1;
        else if (is_ctl && !ext_f && !brk_f) begin
          // device response byte, not a key
        end else begin
          kstb  <= 1'b1;
          code  <= byte_v;
          make  <= ~brk_f;
          ext   <= ext_f;
          ext_f <= 1'b0;
          brk_f <= 1'b0;
        end
      end
    end
  end
endmodule
